// File: rtl/svf_coef_sequencer.sv
// svf_coef_sequencer
// Slews the state-variable filter coefficients F and Q1 toward host-supplied
// targets, moving at most one bounded step per audio sample. Every step is
// taken just after the DAC LR-clock rising edge, so the filter never sees a
// zipper-noise jump.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous, active-low reset
//   sample_clk DAC LR clock, asynchronous to clk
//   req        host offers new targets (accepted when req && ready)
//   f_target   requested F  (unsigned 1.17)
//   q_target   requested Q1 (unsigned 2.16)
//   ready      targets can be accepted this cycle
//   f_out      live F to the filter
//   q_out      live Q1 to the filter
//   busy       live coefficients are still moving toward the targets
//   update     one-cycle pulse when f_out/q_out change
module svf_coef_sequencer #(
  parameter int               FBITS      = 18,
  parameter int               QBITS      = 18,
  parameter int               STEP_SHIFT = 4,
  parameter logic [FBITS-1:0] F_INIT     = 18'h04000,
  parameter logic [QBITS-1:0] Q_INIT     = 18'h10000,
  parameter logic [FBITS-1:0] F_MAX      = 18'h11999,
  parameter logic [QBITS-1:0] Q_MAX      = 18'h20000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_clk,
  input  logic             req,
  input  logic [FBITS-1:0] f_target,
  input  logic [QBITS-1:0] q_target,
  output logic             ready,
  output logic [FBITS-1:0] f_out,
  output logic [QBITS-1:0] q_out,
  output logic             busy,
  output logic             update
);

  // Common width so one slew function serves both coefficients.
  localparam int CW = (FBITS > QBITS) ? FBITS : QBITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  // One slew step: move by (target - live) >>> STEP_SHIFT, but never by less
  // than one LSB while a difference remains. The arithmetic shift can never
  // exceed the difference, so there is no overshoot and no wrap.
  function automatic logic [CW-1:0] slew_step(input logic [CW-1:0] live,
                                              input logic [CW-1:0] tgt);
    logic signed [CW:0] diff;
    logic signed [CW:0] shifted;
    logic signed [CW:0] delta;
    diff    = $signed({1'b0, tgt}) - $signed({1'b0, live});
    shifted = diff >>> STEP_SHIFT;
    if (diff == {(CW+1){1'b0}}) begin
      delta = {(CW+1){1'b0}};
    end else if (shifted == {(CW+1){1'b0}}) begin
      delta = diff[CW] ? {(CW+1){1'b1}} : {{CW{1'b0}}, 1'b1};
    end else begin
      delta = shifted;
    end
    return CW'($signed({1'b0, live}) + delta);
  endfunction

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sync3_q, sync3_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic [FBITS-1:0] f_q, f_d, f_tgt_q, f_tgt_d;
  logic [QBITS-1:0] q_q, q_d, q_tgt_q, q_tgt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             update_q, update_d;

  logic             capture;
  logic [FBITS-1:0] f_cap, f_next;
  logic [QBITS-1:0] q_cap, q_next;

  // Next-state logic: synchronizer, capture/clamp, slew sequencing.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    f_d      = f_q;
    q_d      = q_q;
    f_tgt_d  = f_tgt_q;
    q_tgt_d  = q_tgt_q;
    update_d = 1'b0;

    // Two synchronizer stages plus an edge-detect stage; tick is registered
    // so it lands three clocks after the LR-clock rising edge.
    sync1_d = sample_clk;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    tick_d  = sync2_q & ~sync3_q;

    capture = req & ready_q;
    f_cap   = (f_target > F_MAX) ? F_MAX : f_target;
    q_cap   = (q_target > Q_MAX) ? Q_MAX : q_target;
    f_next  = FBITS'(slew_step(CW'(f_q), CW'(f_tgt_q)));
    q_next  = QBITS'(slew_step(CW'(q_q), CW'(q_tgt_q)));

    case (state_q)
      ST_IDLE: begin
        // A bare tick is meaningless here; a tick coinciding with a capture
        // is remembered so the first step is not delayed a whole sample.
        if (capture) begin
          f_tgt_d = f_cap;
          q_tgt_d = q_cap;
          if ((f_cap != f_q) || (q_cap != q_q)) begin
            state_d = ST_WAIT;
            pend_d  = tick_q;
          end else begin
            pend_d  = 1'b0;
          end
        end else begin
          pend_d = 1'b0;
        end
      end
      ST_WAIT: begin
        // Capture takes priority; any tick seen now is kept as pending.
        if (capture) begin
          f_tgt_d = f_cap;
          q_tgt_d = q_cap;
          if ((f_cap == f_q) && (q_cap == q_q)) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
          end else begin
            pend_d  = pend_q | tick_q;
          end
        end else if (tick_q || pend_q) begin
          state_d = ST_STEP;
          pend_d  = 1'b0;
        end else begin
          pend_d  = pend_q;
        end
      end
      ST_STEP: begin
        f_d      = f_next;
        q_d      = q_next;
        update_d = (f_next != f_q) || (q_next != q_q);
        // A tick landing during the step is carried into the next WAIT.
        pend_d   = tick_q;
        if ((f_next == f_tgt_q) && (q_next == q_tgt_q)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    endcase

    ready_d = (state_d != ST_STEP);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any ramp in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
      f_q      <= F_INIT;
      q_q      <= Q_INIT;
      f_tgt_q  <= F_INIT;
      q_tgt_q  <= Q_INIT;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
      f_q      <= f_d;
      q_q      <= q_d;
      f_tgt_q  <= f_tgt_d;
      q_tgt_q  <= q_tgt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      update_q <= update_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign update = update_q;
  assign f_out  = f_q;
  assign q_out  = q_q;

endmodule

// File: tb/tb_svf_coef_sequencer.sv
// Self-checking bench for svf_coef_sequencer. Expected coefficient pairs are
// pushed to a scoreboard queue whenever a sample edge is driven and popped by
// a monitor whenever the DUT pulses update.
module tb_svf_coef_sequencer;

  logic        clk;
  logic        reset;
  logic        sample_clk;
  logic        req;
  logic [17:0] f_target;
  logic [17:0] q_target;
  logic        ready;
  logic [17:0] f_out;
  logic [17:0] q_out;
  logic        busy;
  logic        update;

  int checks = 0;
  int passes = 0;

  // Bench model of live values and stored targets.
  int mf, mq, tf, tq;
  logic [35:0] exp_q[$];

  svf_coef_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .sample_clk(sample_clk),
    .req       (req),
    .f_target  (f_target),
    .q_target  (q_target),
    .ready     (ready),
    .f_out     (f_out),
    .q_out     (q_out),
    .busy      (busy),
    .update    (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent slew model: floor division by 16, minimum step of one LSB.
  function automatic int model_step(input int l, input int t);
    int d;
    int s;
    d = t - l;
    if (d == 0) return l;
    if (d > 0) s = d / 16;
    else s = -((-d + 15) / 16);
    if (s == 0) s = (d > 0) ? 1 : -1;
    return l + s;
  endfunction

  // Scoreboard monitor: every update pulse must match the next expected pair.
  always @(negedge clk) begin
    logic [35:0] e;
    if (reset && update) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_update: got f_out=%h q_out=%h, expected no update", f_out, q_out);
      end else begin
        e = exp_q.pop_front();
        if ({f_out, q_out} !== e)
          $display("FAIL sb_step: got f_out=%h q_out=%h, expected f=%h q=%h", f_out, q_out, e[35:18], e[17:0]);
        else
          passes++;
      end
    end
  end

  task automatic apply_reset();
    sample_clk = 1'b0;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    mf = 'h04000; mq = 'h10000; tf = mf; tq = mq;
    @(negedge clk);
  endtask

  task automatic capture(input int f, input int q);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      $display("FAIL capture_ready_timeout: ready=%b, expected 1", ready);
    end
    req = 1'b1;
    f_target = f[17:0];
    q_target = q[17:0];
    @(negedge clk);
    req = 1'b0;
    tf = (f > 'h11999) ? 'h11999 : f;
    tq = (q > 'h20000) ? 'h20000 : q;
  endtask

  // One full LR-clock period; pushes the expected step if one is due.
  task automatic sample_pulse();
    if (mf != tf || mq != tq) begin
      mf = model_step(mf, tf);
      mq = model_step(mq, tq);
      exp_q.push_back({mf[17:0], mq[17:0]});
    end
    sample_clk = 1'b1;
    repeat (6) @(negedge clk);
    sample_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic saw_update;
    saw_update = 1'b0;
    reset = 1'b0;
    sample_clk = 1'b0;
    req = 1'b0;
    f_target = '0;
    q_target = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i % 3 == 0) sample_clk = ~sample_clk;
      if (update !== 1'b0) saw_update = 1'b1;
    end
    checks++;
    if (saw_update !== 1'b0) $display("FAIL reset_update: saw update=1, expected 0"); else passes++;
    checks++;
    if (f_out !== 18'h04000) $display("FAIL reset_f: got %h, expected 04000", f_out); else passes++;
    checks++;
    if (q_out !== 18'h10000) $display("FAIL reset_q: got %h, expected 10000", q_out); else passes++;
    checks++;
    if (ready !== 1'b1) $display("FAIL reset_ready: got %b, expected 1", ready); else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else passes++;
    sample_clk = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mf = 'h04000; mq = 'h10000; tf = mf; tq = mq;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_up_ramp();
    int n;
    capture('h08000, 'h10000);
    checks++;
    if (busy !== 1'b1) $display("FAIL up_busy: got %b, expected 1", busy); else passes++;
    // First step with latency check: 5 clocks after the rising edge.
    mf = model_step(mf, tf);
    mq = model_step(mq, tq);
    exp_q.push_back({mf[17:0], mq[17:0]});
    sample_clk = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (f_out !== 18'h04000) $display("FAIL up_latency_early: got %h, expected 04000", f_out); else passes++;
    @(negedge clk);
    checks++;
    if (f_out !== 18'h04400 || q_out !== 18'h10000 || update !== 1'b1)
      $display("FAIL up_first_step: got f=%h q=%h upd=%b, expected f=04400 q=10000 upd=1", f_out, q_out, update);
    else passes++;
    @(negedge clk);
    sample_clk = 1'b0;
    repeat (4) @(negedge clk);
    n = 0;
    while ((mf != tf || mq != tq) && n < 400) begin
      sample_pulse();
      n++;
    end
    checks++;
    if (f_out !== 18'h08000 || busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL up_final: got f=%h busy=%b pending=%0d, expected f=08000 busy=0 pending=0", f_out, busy, exp_q.size());
    else passes++;
    repeat (3) sample_pulse();
    checks++;
    if (f_out !== 18'h08000) $display("FAIL up_hold: got %h, expected 08000", f_out); else passes++;
  endtask

  task automatic test_down_min_step();
    logic [17:0] seq [4];
    seq[0] = 18'h03FFF; seq[1] = 18'h03FFE; seq[2] = 18'h03FFD; seq[3] = 18'h03FFC;
    apply_reset();
    capture('h03FFC, 'h10000);
    for (int i = 0; i < 4; i++) begin
      sample_pulse();
      checks++;
      if (f_out !== seq[i]) $display("FAIL down_step%0d: got %h, expected %h", i, f_out, seq[i]); else passes++;
    end
    repeat (2) sample_pulse();
    checks++;
    if (f_out !== 18'h03FFC || busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL down_hold: got f=%h busy=%b pending=%0d, expected f=03ffc busy=0 pending=0", f_out, busy, exp_q.size());
    else passes++;
  endtask

  task automatic test_clamp();
    int n;
    capture('h3FFFF, 'h3FFFF);
    n = 0;
    while ((mf != tf || mq != tq) && n < 400) begin
      sample_pulse();
      n++;
    end
    repeat (2) sample_pulse();
    checks++;
    if (f_out !== 18'h11999) $display("FAIL clamp_f: got %h, expected 11999", f_out); else passes++;
    checks++;
    if (q_out !== 18'h20000) $display("FAIL clamp_q: got %h, expected 20000", q_out); else passes++;
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL clamp_settle: got busy=%b pending=%0d, expected 0 and 0", busy, exp_q.size());
    else passes++;
  endtask

  task automatic test_retarget();
    logic [17:0] prev;
    apply_reset();
    capture('h08000, 'h10000);
    repeat (3) sample_pulse();
    prev = f_out;
    // Tick is registered three clocks after the edge; capture lands with it.
    sample_clk = 1'b1;
    repeat (3) @(negedge clk);
    req = 1'b1;
    f_target = 18'h02000;
    q_target = 18'h10000;
    tf = 'h02000;
    mf = model_step(mf, tf);
    mq = model_step(mq, tq);
    exp_q.push_back({mf[17:0], mq[17:0]});
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (!(f_out < prev) || update !== 1'b1)
      $display("FAIL retarget_down: got f=%h upd=%b, expected below %h with upd=1", f_out, update, prev);
    else passes++;
    sample_clk = 1'b0;
    repeat (4) @(negedge clk);
    sample_pulse();
    checks++;
    if (busy !== 1'b1 || exp_q.size() != 0)
      $display("FAIL retarget_ramping: got busy=%b pending=%0d, expected 1 and 0", busy, exp_q.size());
    else passes++;
    // Asynchronous reset away from any clock edge.
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (f_out !== 18'h04000 || q_out !== 18'h10000 || busy !== 1'b0 || ready !== 1'b1)
      $display("FAIL async_reset: got f=%h q=%h busy=%b ready=%b, expected 04000 10000 0 1", f_out, q_out, busy, ready);
    else passes++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    mf = 'h04000; mq = 'h10000; tf = mf; tq = mq;
    @(negedge clk);
  endtask

  task automatic test_no_tick();
    logic moved;
    logic pulsed;
    moved = 1'b0;
    pulsed = 1'b0;
    sample_clk = 1'b0;
    capture('h08000, 'h10000);
    checks++;
    if (busy !== 1'b1) $display("FAIL notick_busy: got %b, expected 1", busy); else passes++;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (f_out !== 18'h04000) moved = 1'b1;
      if (update !== 1'b0) pulsed = 1'b1;
    end
    checks++;
    if (moved !== 1'b0) $display("FAIL notick_hold: f_out moved to %h, expected 04000", f_out); else passes++;
    checks++;
    if (pulsed !== 1'b0) $display("FAIL notick_update: saw update=1, expected 0"); else passes++;
  endtask

  initial begin
    test_reset();
    test_up_ramp();
    test_down_min_step();
    test_clamp();
    test_retarget();
    test_no_tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/svf_coef_sequencer.md
Name: svf_coef_sequencer

Overview:
Sequences the frequency (F) and damping (Q1) coefficients of the state-variable filter from a host or user-control side. It accepts target coefficients through a req/ready handshake. It slews the live coefficients toward the targets by one bounded step per audio sample, so the filter never sees a zipper-noise jump. Updates happen only just after the DAC LR-clock rising edge. It sits between control logic (button/UART/pot readers) and the filter's F/Q1 inputs.

Parameters:
FBITS, 18, width of F (unsigned fixed point 1.17)
QBITS, 18, width of Q1 (unsigned fixed point 2.16)
STEP_SHIFT, 4, slew divisor: step = (target - current) >>> STEP_SHIFT
F_INIT, 18'h04000, F value at reset
Q_INIT, 18'h10000, Q1 value at reset (Q = 1)
F_MAX, 18'h11999, F clamp (~0.55)
Q_MAX, 18'h20000, Q1 clamp (2.0, Q = 0.5)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; 0 = reset
sample_clk  in  1  DAC LR clock, asynchronous to clk
req  in  1  host offers new targets
f_target  in  FBITS  requested F
q_target  in  QBITS  requested Q1
ready  out  1  targets accepted when req && ready
f_out  out  FBITS  live F to filter
q_out  out  QBITS  live Q1 to filter
busy  out  1  live coefficients differ from targets
update  out  1  one-cycle pulse when f_out/q_out change

Behaviour:
- Reset (reset=0, async): f_out=F_INIT, q_out=Q_INIT, stored targets = init values, state=IDLE, ready=1, busy=0, update=0, sync flops=0, pending tick=0. Reset mid-ramp abandons the ramp.
- sample_clk path: 2-FF synchronizer, then a third flop for edge detection. tick = 1-cycle pulse 3 clk after the sample_clk rising edge. Falling edges are ignored.
- Capture: on req && ready, store min(f_target, F_MAX) and min(q_target, Q_MAX). Capture is allowed in IDLE and WAIT. A capture retargets any ramp in progress from the current live values.
- FSM:
  IDLE: live == targets. A tick is ignored. A capture that differs from live goes to WAIT. A capture equal to live stays in IDLE.
  WAIT: waits for a tick, or a pending tick flag, then goes to STEP.
  STEP: single cycle; ready=0. Computes and registers the next f_out/q_out; update=1 on the following cycle. Then goes to IDLE if both equal their targets, else WAIT.
- Step arithmetic (each coefficient independently):
  diff = target - live, signed, width+1.
  delta = diff >>> STEP_SHIFT.
  If delta == 0 and diff != 0, delta = +1 or -1 per the sign of diff.
  live += delta.
  No overshoot, no wrap; a coefficient already at target does not change.
- Simultaneous capture and tick in the same cycle: the capture is applied first and the tick is held as pending. The following STEP uses the new targets.
- A tick arriving during STEP is held as pending and consumed in the next WAIT, so no sample is lost.
- busy = (state != IDLE).
- update is high only in the cycle after STEP, and only if at least one output changed.
- Latency: the first coefficient change appears on f_out/q_out 5 clk after the sample_clk rising edge. Outputs stay constant at all other times.

Test Plan:
- Reset: hold reset=0, toggle sample_clk -> f_out=0x04000, q_out=0x10000, ready=1, busy=0, update never asserted.
- Up-ramp: req with f_target=0x08000, q_target=0x10000, then 1 sample_clk rising edge -> f_out=0x04400 5 clk after the edge, q_out unchanged. Continued edges make f_out increase monotonically and reach exactly 0x08000, then busy=0 and no further update pulses.
- Down-ramp with min step: from f_out=0x04000, target 0x03FFC -> f_out follows 0x03FFF, 0x03FFE, 0x03FFD, 0x03FFC, one step per sample edge, never below 0x03FFC.
- Clamp: q_target=0x3FFFF -> q_out settles at exactly 0x20000. f_target=0x3FFFF -> f_out settles at 0x11999.
- Retarget mid-ramp and coincident events: capture 0x08000; after 3 edges capture 0x02000 in the same cycle as a tick -> the next step moves f_out downward. Assert reset during a ramp -> outputs return to init values immediately (asynchronously).
- No-tick hold: capture a new target with sample_clk static -> busy=1, f_out unchanged for 1000 clk, update stays 0.
